// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the IF/LS pipeline stages, the shared memory and the arbiter.
// The arbiter takes the slave view; whatever drives the stages and the memory takes the master view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_kill;
    logic                  if_done;
    logic [DATA_W-1:0]     if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_W-1:0]     ls_addr;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_be;
    logic                  ls_done;
    logic [DATA_W-1:0]     ls_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  owner;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_done, if_rdata, ls_done, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output owner
    );

    modport master (
        output if_req, if_addr, if_kill,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_done, if_rdata, ls_done, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  owner
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// LS normally wins; IF is forced through after MAX_IF_WAIT consecutive losses.
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_arbiter_if.slave   bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_IF_WAIT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IF_WAIT);

    logic [1:0]        state_q,    state_d;
    logic              owner_q,    owner_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [BE_W-1:0]   be_q,       be_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              kill_q,     kill_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic grant_if;

    assign grant_if = bus.if_req && (!bus.ls_req || (wait_cnt_q == CNT_MAX));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wait_cnt_d = wait_cnt_q;
        kill_d     = kill_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        // A branch correction marks the fetch dead; the bus transaction still runs to completion.
        if ((state_q != ST_IDLE) && !owner_q && bus.if_kill) begin
            kill_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    state_d = ST_REQ;
                    if (grant_if) begin
                        owner_d    = 1'b0;
                        we_d       = 1'b0;
                        addr_d     = bus.if_addr;
                        wdata_d    = '0;
                        be_d       = '1;
                        wait_cnt_d = '0;
                    end else begin
                        owner_d = 1'b1;
                        we_d    = bus.ls_we;
                        addr_d  = bus.ls_addr;
                        wdata_d = bus.ls_wdata;
                        be_d    = bus.ls_be;
                        // IF lost this round; count stays below CNT_MAX here, so it saturates.
                        if (bus.if_req) begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    state_d = we_q ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        ls_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wait_cnt_q <= '0;
            kill_q     <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wait_cnt_q <= wait_cnt_d;
            kill_q     <= kill_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.mem_req   = (state_q == ST_REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.owner     = owner_q;

    // A kill landing in the RESP cycle itself must also hide the pulse.
    assign bus.if_done  = (state_q == ST_RESP) && !owner_q && !kill_q && !bus.if_kill;
    assign bus.ls_done  = (state_q == ST_RESP) && owner_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule
